// File: rtl/regfile_mp.sv
// Multi-read-port register file with async clear, optional write-through bypass and a pending scoreboard.
// Reads and reserveReject are combinational (0 cycles); writes/reserves commit at posedge; no backpressure, rejected reserves are dropped.
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           regWrite,
  input  logic [ADDR_WIDTH-1:0]          writeAddr,
  input  logic [WIDTH-1:0]               writeData,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ*WIDTH-1:0]      readData,
  output logic [NUM_READ-1:0]            readPending,
  input  logic                           reserve,
  input  logic [ADDR_WIDTH-1:0]          reserveAddr,
  output logic                           reserveReject,
  output logic [ADDR_WIDTH:0]            pendingCount,
  output logic                           anyPending
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  logic wr_en;
  logic rsv_en;
  logic same_addr;
  logic cnt_inc;
  logic cnt_dec;

  // A reserve on a pending register is still accepted when the same register
  // is written back this cycle: the write retires the old producer.
  always_comb begin
    same_addr = (writeAddr == reserveAddr);
    wr_en     = regWrite && (writeAddr != '0);
    rsv_en    = reserve && (reserveAddr != '0) &&
                (!pend_q[reserveAddr] || (wr_en && same_addr));
    cnt_inc   = rsv_en && !pend_q[reserveAddr];
    cnt_dec   = wr_en && pend_q[writeAddr] && !(rsv_en && same_addr);
  end

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      mem_d[writeAddr]  = writeData;
      pend_d[writeAddr] = 1'b0;
    end
    // Reserve applied after the write so a same-address reserve wins.
    if (rsv_en) begin
      pend_d[reserveAddr] = 1'b1;
    end
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic                  zero;

    assign addr = readAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) && regWrite && (writeAddr == addr);
    // Outputs are gated by reset so a bypassed write cannot leak while cleared.
    assign zero = !reset || (addr == '0);
    assign readData[k*WIDTH +: WIDTH] = zero ? '0 : (hit ? writeData : mem_q[addr]);
    assign readPending[k] = !zero && pend_q[addr] && !hit;
  end

  assign reserveReject = reset && reserve && (reserveAddr != '0) &&
                         pend_q[reserveAddr] && !(regWrite && same_addr);
  assign pendingCount  = cnt_q;
  assign anyPending    = reset && (cnt_q != '0);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised + directed scoreboard bench for regfile_mp (4 read ports, bypass and non-bypass instances).
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic         regWrite;
  logic [4:0]   writeAddr;
  logic [31:0]  writeData;
  logic [19:0]  readAddr;
  logic         reserve;
  logic [4:0]   reserveAddr;

  logic [127:0] rd_b, rd_n;
  logic [3:0]   rp_b, rp_n;
  logic         rej_b, rej_n;
  logic [5:0]   cnt_b, cnt_n;
  logic         any_b, any_n;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .readAddr(readAddr), .readData(rd_b),
    .readPending(rp_b), .reserve(reserve), .reserveAddr(reserveAddr),
    .reserveReject(rej_b), .pendingCount(cnt_b), .anyPending(any_b)
  );

  regfile_mp #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .readAddr(readAddr), .readData(rd_n),
    .readPending(rp_n), .reserve(reserve), .reserveAddr(reserveAddr),
    .reserveReject(rej_n), .pendingCount(cnt_n), .anyPending(any_n)
  );

  typedef struct packed {
    logic [127:0] rd_b;
    logic [127:0] rd_n;
    logic [3:0]   rp_b;
    logic [3:0]   rp_n;
    logic         rej;
    logic [5:0]   cnt;
    logic         any;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural contents and the set of in-flight registers.
  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("readData_byp",    rd_b,  e.rd_b);
      check("readData_nobyp",  rd_n,  e.rd_n);
      check("readPending_byp", {124'b0, rp_b}, {124'b0, e.rp_b});
      check("readPending_nobyp", {124'b0, rp_n}, {124'b0, e.rp_n});
      check("reserveReject_byp",   {127'b0, rej_b}, {127'b0, e.rej});
      check("reserveReject_nobyp", {127'b0, rej_n}, {127'b0, e.rej});
      check("pendingCount_byp",    {122'b0, cnt_b}, {122'b0, e.cnt});
      check("pendingCount_nobyp",  {122'b0, cnt_n}, {122'b0, e.cnt});
      check("anyPending_byp",      {127'b0, any_b}, {127'b0, e.any});
      check("anyPending_nobyp",    {127'b0, any_n}, {127'b0, e.any});
    end
  end

  function automatic logic [19:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [4:0] b0, b1, b2, b3;
    b0 = 5'(a0); b1 = 5'(a1); b2 = 5'(a2); b3 = 5'(a3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_pend = '0;
  endtask

  // Expected outputs for the inputs currently driven, from the behavioural rules.
  task automatic push_expect();
    exp_t e;
    int   a;
    logic bypassed;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      a = int'(readAddr[k*5 +: 5]);
      bypassed = regWrite && (int'(writeAddr) == a);
      if (reset && a != 0) begin
        e.rd_n[k*32 +: 32] = m_mem[a];
        e.rp_n[k]          = m_pend[a];
        e.rd_b[k*32 +: 32] = bypassed ? writeData : m_mem[a];
        e.rp_b[k]          = bypassed ? 1'b0 : m_pend[a];
      end
    end
    e.rej = reset && reserve && reserveAddr != 0 && m_pend[reserveAddr] &&
            !(regWrite && writeAddr == reserveAddr);
    e.cnt = 6'($countones(m_pend));
    e.any = reset && (e.cnt != 0);
    exp_q.push_back(e);
  endtask

  task automatic model_commit();
    logic old_pend_r;
    old_pend_r = m_pend[reserveAddr];
    if (regWrite && writeAddr != 0) begin
      m_mem[writeAddr]  = writeData;
      m_pend[writeAddr] = 1'b0;
    end
    // A reserve takes effect if the register was free, or was being retired by this very write.
    if (reserve && reserveAddr != 0 &&
        (!old_pend_r || (regWrite && writeAddr == reserveAddr))) begin
      m_pend[reserveAddr] = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                      input logic rsv, input int ra, input logic [19:0] rds);
    reset       = rst;
    regWrite    = we;
    writeAddr   = 5'(wa);
    writeData   = wd;
    reserve     = rsv;
    reserveAddr = 5'(ra);
    readAddr    = rds;
    if (!rst) model_clear();
    push_expect();
    @(posedge clk);
    if (reset) model_commit();
    #1;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 5));
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    reset = 1'b0; regWrite = 1'b0; writeAddr = '0; writeData = '0;
    reserve = 1'b0; reserveAddr = '0; readAddr = '0;
    model_clear();
    @(posedge clk);
    #1;

    // Under reset: outputs zero, write/reserve ignored.
    step(0, 1, 8, 32'h1234, 1, 9, pack4(8, 9, 0, 31));
    step(1, 1, 8, 32'h1234, 0, 0, pack4(8, 0, 0, 0));
    step(1, 0, 0, 0, 0, 0, pack4(8, 8, 8, 8));
    // Async clear with prior contents, then resume from cleared state.
    step(0, 0, 0, 0, 0, 0, pack4(8, 8, 8, 8));
    step(1, 0, 0, 0, 0, 0, pack4(8, 8, 8, 8));

    // Same-cycle write/read of reg 10.
    step(1, 1, 10, 32'hdeadbeef, 0, 0, pack4(0, 10, 0, 0));
    step(1, 0, 0, 0, 0, 0, pack4(0, 10, 10, 10));

    // Register 0 is hardwired.
    step(1, 1, 0, 32'hffffffff, 1, 0, pack4(0, 0, 0, 0));
    step(1, 0, 0, 0, 0, 0, pack4(0, 0, 0, 0));

    // Reserve 9, duplicate reserve rejected, write-back clears.
    step(1, 0, 0, 0, 1, 9, pack4(9, 9, 9, 9));
    step(1, 0, 0, 0, 1, 9, pack4(9, 9, 9, 9));
    step(1, 1, 9, 32'h5, 0, 0, pack4(9, 9, 9, 9));
    step(1, 0, 0, 0, 0, 0, pack4(9, 9, 9, 9));

    // Reserve and write of pending reg 11 in one cycle: new producer.
    step(1, 0, 0, 0, 1, 11, pack4(11, 0, 0, 0));
    step(1, 1, 11, 32'h7, 1, 11, pack4(11, 11, 0, 0));
    step(1, 0, 0, 0, 0, 0, pack4(11, 11, 11, 11));

    // Four ports {0,8,8,31}, then async reset.
    step(1, 1, 8, 32'hA, 0, 0, pack4(0, 8, 8, 31));
    step(1, 1, 31, 32'hB, 0, 0, pack4(0, 8, 8, 31));
    step(1, 0, 0, 0, 0, 0, pack4(0, 8, 8, 31));
    step(0, 0, 0, 0, 0, 0, pack4(0, 8, 8, 31));
    step(1, 0, 0, 0, 0, 0, pack4(0, 8, 8, 31));

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), rand_addr(), $urandom(),
           ($urandom_range(0, 9) < 5), rand_addr(),
           pack4(rand_addr(), rand_addr(), rand_addr(), rand_addr()));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
